// File: rtl/main_mem_pkg.sv
// Shared types and defaults for the main-memory responder and its RAM array.
package main_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATENCY,
    S_BURST,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int DEF_MEM_LATENCY    = 3;
  localparam int DEF_WORDS_PER_LINE = 4;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/main_mem_array.sv
// Single-port synchronous RAM, one-cycle read latency; read register only
// updates on re, so the last word read stays on rdata.
module main_mem_array
  import main_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Contents are never reset; only the output register is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: line-refill bursts and write-through word commits.
// Optional MAIN_MEM_STATS_EN adds saturating read-line / write-word counters.
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int MEM_LATENCY    = DEF_MEM_LATENCY
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_rw,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic [DATA_W-1:0]                 req_wdata,
  output logic                              rsp_valid,
  output logic [DATA_W-1:0]                 rsp_data,
  output logic [$clog2(WORDS_PER_LINE)-1:0] rsp_word_idx,
  output logic                              data_ready_m,
  output logic                              write_done,
  output logic                              busy
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [15:0]                       stat_rd_lines,
  output logic [15:0]                       stat_wr_words
`endif
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  state_t            state;
  logic [CNT_W-1:0]  lat_cnt;
  logic [IDX_W-1:0]  word_idx;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_lat;
  logic              last_word;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;

  assign last_lat     = (lat_cnt == CNT_W'(1));
  assign last_word    = (word_idx == IDX_W'(WORDS_PER_LINE - 1));
  assign busy         = ~req_ready;
  assign rsp_word_idx = word_idx;

  // Reads run one word ahead of rsp_valid to cover the RAM's read latency.
  always_comb begin
    mem_we   = (state == S_WRITE);
    mem_re   = 1'b0;
    mem_addr = addr_q;
    if (state == S_LATENCY && last_lat && rw_q == REQ_READ) begin
      mem_re   = 1'b1;
      mem_addr = {addr_q[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
    end else if (state == S_BURST && !last_word) begin
      mem_re   = 1'b1;
      mem_addr = {addr_q[ADDR_W-1:IDX_W], word_idx + IDX_W'(1)};
    end
  end

  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      rw_q    <= req_rw;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      data_ready_m <= 1'b0;
      write_done   <= 1'b0;
      lat_cnt      <= '0;
      word_idx     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state     <= S_LATENCY;
            req_ready <= 1'b0;
            lat_cnt   <= CNT_W'(MEM_LATENCY);
            word_idx  <= '0;
          end
        end
        S_LATENCY: begin
          lat_cnt <= lat_cnt - CNT_W'(1);
          if (last_lat) begin
            if (rw_q == REQ_WRITE) begin
              state <= S_WRITE;
            end else begin
              state     <= S_BURST;
              rsp_valid <= 1'b1;
            end
          end
        end
        S_BURST: begin
          if (last_word) begin
            state        <= S_DONE;
            rsp_valid    <= 1'b0;
            word_idx     <= '0;
            data_ready_m <= 1'b1;
          end else begin
            word_idx <= word_idx + IDX_W'(1);
          end
        end
        S_WRITE: begin
          state      <= S_DONE;
          write_done <= 1'b1;
        end
        S_DONE: begin
          state        <= S_IDLE;
          data_ready_m <= 1'b0;
          write_done   <= 1'b0;
          req_ready    <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  main_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(wdata_q),
    .rdata(rsp_data)
  );

`ifdef MAIN_MEM_STATS_EN
  logic [15:0] stat_rd_q;
  logic [15:0] stat_wr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      if (data_ready_m && stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 16'd1;
      if (write_done && stat_wr_q != 16'hFFFF)   stat_wr_q <= stat_wr_q + 16'd1;
    end
  end

  assign stat_rd_lines = stat_rd_q;
  assign stat_wr_words = stat_wr_q;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: transaction-level model checked every cycle
// plus directed literal expectations on latency, burst order and reset.
module tb_main_mem_responder;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int W      = 4;
  localparam int L      = 3;
  localparam int IW     = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_rw = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready, rsp_valid, data_ready_m, write_done, busy;
  logic [DATA_W-1:0] rsp_data;
  logic [IW-1:0]     rsp_word_idx;
`ifdef MAIN_MEM_STATS_EN
  logic [15:0]       stat_rd_lines, stat_wr_words;
`endif

  main_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_LINE(W), .MEM_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_word_idx(rsp_word_idx),
    .data_ready_m(data_ready_m), .write_done(write_done), .busy(busy)
`ifdef MAIN_MEM_STATS_EN
    , .stat_rd_lines(stat_rd_lines), .stat_wr_words(stat_wr_words)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(logic [ADDR_W-1:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  // Transaction model: memory image plus the one outstanding request.
  logic [DATA_W-1:0] mmem  [1<<ADDR_W];
  bit                known [1<<ADDR_W];
  int                cyc = 0;
  bit                m_act = 1'b0;
  bit                m_rw = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  int                m_acc = 0;
  logic [DATA_W-1:0] m_last = '0;
  bit                m_last_known = 1'b1;
  int unsigned       m_rd = 0;
  int unsigned       m_wr = 0;

  int dut_acc_n = 0;
  int dut_acc_cyc[$];
  int obs_wd_n, obs_drp_n, obs_v_first, obs_v_last, obs_v_cnt;
  logic [DATA_W-1:0] obs_word [W];

  task automatic clr_obs();
    obs_wd_n = -1; obs_drp_n = -1; obs_v_first = -1; obs_v_last = -1; obs_v_cnt = 0;
    for (int k = 0; k < W; k++) obs_word[k] = '0;
  endtask

  always @(posedge clk) begin
    int n;
    if (req_valid && req_ready && !reset) begin
      dut_acc_n++;
      dut_acc_cyc.push_back(cyc);
    end
    if (reset) begin
      m_act = 1'b0; m_last = '0; m_last_known = 1'b1; m_rd = 0; m_wr = 0;
    end else if (m_act) begin
      n = cyc - m_acc;
      if (m_rw && n == L + 1) begin mmem[m_addr] = m_wdata; known[m_addr] = 1'b1; end
      if (!m_rw && n == L + W + 1 && m_rd != 16'hFFFF) m_rd++;
      if (m_rw && n == L + 2 && m_wr != 16'hFFFF) m_wr++;
      if (n + 1 >= (m_rw ? L + 3 : L + W + 2)) m_act = 1'b0;
    end else if (req_valid) begin
      m_act = 1'b1; m_rw = req_rw; m_addr = req_addr; m_wdata = req_wdata; m_acc = cyc;
    end
    cyc++;
    n = cyc - m_acc;
    if (m_act && !m_rw && n >= L + 1 && n <= L + W) begin
      m_last       = mmem[(m_addr & 10'h3FC) | ADDR_W'(n - L - 1)];
      m_last_known = known[(m_addr & 10'h3FC) | ADDR_W'(n - L - 1)];
    end
  end

  always @(negedge clk) begin
    int n;
    bit e_v, e_drp, e_wd;
    n     = cyc - m_acc;
    e_v   = m_act && !m_rw && n >= L + 1 && n <= L + W;
    e_drp = m_act && !m_rw && n == L + W + 1;
    e_wd  = m_act && m_rw && n == L + 2;
    chk("req_ready", req_ready, !m_act);
    chk("busy", busy, m_act);
    chk("rsp_valid", rsp_valid, e_v);
    chk("data_ready_m", data_ready_m, e_drp);
    chk("write_done", write_done, e_wd);
    if (e_v) chk("rsp_word_idx", rsp_word_idx, n - L - 1);
    if (m_last_known) chk("rsp_data", rsp_data, m_last);
`ifdef MAIN_MEM_STATS_EN
    chk("stat_rd_lines", stat_rd_lines, m_rd);
    chk("stat_wr_words", stat_wr_words, m_wr);
`endif
    if (write_done) obs_wd_n = n;
    if (data_ready_m) obs_drp_n = n;
    if (rsp_valid) begin
      if (obs_v_first < 0) obs_v_first = n;
      obs_v_last = n;
      obs_v_cnt++;
      obs_word[rsp_word_idx] = rsp_data;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (m_act && t < 100) begin @(negedge clk); t++; end
    if (m_act) begin
      checks++; errors++;
      $display("FAIL idle_timeout: model still busy after %0d cycles, required idle", t);
    end
  endtask

  task automatic start_req(bit rw, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    wait_idle();
    clr_obs();
    @(negedge clk); #1;
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
    @(negedge clk); #1;
    req_valid = 1'b0; req_rw = ~rw; req_addr = ADDR_W'($urandom); req_wdata = $urandom;
  endtask

  task automatic issue(bit rw, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    start_req(rw, a, d);
    wait_idle();
  endtask

  initial begin
    logic [ADDR_W-1:0] prep [8];
    int t, base_acc;
    prep = '{10'h004, 10'h006, 10'h007, 10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF, 10'h000};
    for (int i = 0; i < (1 << ADDR_W); i++) begin mmem[i] = '0; known[i] = 1'b0; end
    clr_obs();

    // Reset defaults
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_word_idx", rsp_word_idx, 2'd0);
    #1 reset = 1'b0;

    foreach (prep[i]) issue(1'b1, prep[i], pat(prep[i]));

    // Write then read back
    issue(1'b1, 10'h005, 32'hDEADBEEF);
    chk("wr_done_cycle", obs_wd_n, 5);
    issue(1'b0, 10'h006, 32'h0);
    chk("rd_first_valid", obs_v_first, 4);
    chk("rd_last_valid", obs_v_last, 7);
    chk("rd_ready_m_cycle", obs_drp_n, 8);
    chk("rd_word0", obs_word[0], pat(10'h004));
    chk("rd_word1", obs_word[1], 32'hDEADBEEF);
    chk("rd_word3", obs_word[3], pat(10'h007));

    // Busy rejection: req_valid held across a whole read
    wait_idle();
    base_acc = dut_acc_n;
    @(negedge clk); #1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 10'h004;
    t = 0;
    while (dut_acc_n < base_acc + 2 && t < 40) begin @(negedge clk); t++; end
    #1 req_valid = 1'b0;
    chk("busy_accepts", dut_acc_n - base_acc, 2);
    chk("busy_next_acc_gap", dut_acc_cyc[$] - dut_acc_cyc[$-1], 9);
    wait_idle();

    // Line-top burst stays inside 0x3FC..0x3FF
    issue(1'b0, 10'h3FF, 32'h0);
    for (int k = 0; k < W; k++) chk("top_word", obs_word[k], pat(ADDR_W'(10'h3FC + k)));

    // Reset in cycle 5 of a read
    start_req(1'b0, 10'h3FC, 32'h0);
    t = 0;
    while (m_act && (cyc - m_acc) < 5 && t < 20) begin @(negedge clk); t++; end
    chk("rst_mid_in_burst", rsp_valid, 1'b1);
    #1 reset = 1'b1;
    clr_obs();
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_valid", obs_v_cnt, 0);
    chk("rst_mid_no_ready_m", obs_drp_n, -1);
    chk("rst_mid_req_ready", req_ready, 1'b1);
    issue(1'b0, 10'h3FC, 32'h0);
    chk("rst_mid_word0", obs_word[0], pat(10'h3FC));
    chk("rst_mid_word2", obs_word[2], pat(10'h3FE));

`ifdef MAIN_MEM_STATS_EN
    // Saturation of the read-line counter
    wait_idle();
    @(negedge clk); #1;
    force dut.stat_rd_q = 16'hFFFF;
    m_rd = 16'hFFFF;
    @(negedge clk); #1;
    release dut.stat_rd_q;
    issue(1'b0, 10'h004, 32'h0);
    chk("stat_rd_sat", stat_rd_lines, 16'hFFFF);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
